// File: rtl/inst_sequencer_if.sv
// Switch, core-handshake and status signals of the instruction sequencer.
// master is the sequencer's view; slave is the environment (switches + core).
interface inst_sequencer_if;
    logic       SW_START;
    logic [1:0] SW_MODE;
    logic [7:0] SW_INST;
    logic       DONE;
    logic [7:0] INST;
    logic       GO;
    logic [3:0] PC;
    logic       BUSY;
    logic       HALTED;
    logic       ERR;

    modport master (
        input  SW_START, SW_MODE, SW_INST, DONE,
        output INST, GO, PC, BUSY, HALTED, ERR
    );

    modport slave (
        output SW_START, SW_MODE, SW_INST, DONE,
        input  INST, GO, PC, BUSY, HALTED, ERR
    );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction sequencer feeding the 4-bit ALU core: 16x8 program memory, PC,
// debounced start/mode switches and a GO/DONE handshake with timeout halt.

module inst_sequencer_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sync_b;
    logic [WIDTH-1:0] last;
    logic [CNT_W-1:0] cnt;

    // cnt holds how many consecutive identical samples differ from clean.
    // NOTE: every register here uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            last   <= '0;
            clean  <= '0;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            last   <= sync_b;
            if (sync_b == clean) begin
                cnt <= '0;
            end else if (sync_b != last) begin
                cnt <= CNT_W'(1);
            end else if (cnt >= CNT_W'(CYCLES - 1)) begin
                clean <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module inst_sequencer #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          TIMEOUT_CYCLES  = 1024,
    parameter logic [7:0]  HALT_INST       = 8'hFF
) (
    input  logic               CLK,
    input  logic               RST,
    inst_sequencer_if.master   bus
);
    localparam int         TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RUN_NEXT,
        HALT
    } state_t;

    state_t           state;
    logic [7:0]       mem [16];
    logic [3:0]       pc;
    logic [7:0]       inst;
    logic             go;
    logic             busy;
    logic             halted;
    logic             err;
    logic [TMO_W-1:0] wait_cnt;

    logic             start_clean;
    logic             start_prev;
    logic [1:0]       mode;
    logic             press;
    logic             load_wr;

    inst_sequencer_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (CLK),
        .rst   (RST),
        .raw   (bus.SW_START),
        .clean (start_clean)
    );

    inst_sequencer_debounce #(.WIDTH(2), .CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (CLK),
        .rst   (RST),
        .raw   (bus.SW_MODE),
        .clean (mode)
    );

    assign press   = start_clean & ~start_prev;
    assign load_wr = (state == IDLE) && press && (mode == MODE_LOAD);

    // NOTE: program memory has no reset so it keeps its contents across RST.
    always_ff @(posedge CLK) begin
        if (!RST && load_wr) begin
            mem[pc] <= bus.SW_INST;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            pc         <= 4'd0;
            inst       <= 8'h00;
            go         <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            start_prev <= 1'b0;
        end else begin
            start_prev <= start_clean;
            go         <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        if (mode == MODE_LOAD) begin
                            pc <= pc + 4'd1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // GO and the new INST appear together in the first WAIT cycle.
                    inst     <= mem[pc];
                    go       <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.DONE) begin
                        pc <= pc + 4'd1;
                        if (inst == HALT_INST) begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else if (mode == MODE_RUN) begin
                            state <= RUN_NEXT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        err    <= 1'b1;
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RUN_NEXT: begin
                    state <= ISSUE;
                end
                HALT: begin
                    if (mode == MODE_LOAD) begin
                        pc     <= 4'd0;
                        err    <= 1'b0;
                        halted <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INST   = inst;
    assign bus.GO     = go;
    assign bus.PC     = pc;
    assign bus.BUSY   = busy;
    assign bus.HALTED = halted;
    assign bus.ERR    = err;
endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: bounce, load/step, run-to-halt,
// timeout, PC wrap and reset during WAIT, with a 3-cycle core model.
module tb_inst_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_sequencer_if bus ();

    inst_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (16),
        .HALT_INST       (8'hFF)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         go_count  = 0;
    int         go_double = 0;
    int         go_cyc    = 0;
    int         halt_cyc  = -1;
    logic       go_prev   = 1'b0;
    logic       halt_prev = 1'b0;
    logic [7:0] go_inst [$];

    logic       core_en     = 1'b0;
    logic       manual_done = 1'b0;
    int         core_cnt    = 0;

    // Observer: logs every GO with its INST and the cycle HALTED rises.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.GO) begin
                go_count++;
                go_inst.push_back(bus.INST);
                go_cyc = cyc;
                if (go_prev) go_double++;
            end
            go_prev = bus.GO;
            if (bus.HALTED && !halt_prev) halt_cyc = cyc;
            halt_prev = bus.HALTED;
        end
    end

    // Core model: one-cycle DONE three cycles after each GO when enabled.
    initial begin
        bus.DONE = 1'b0;
        forever begin
            @(negedge clk);
            if (core_cnt > 0) begin
                core_cnt--;
                bus.DONE = (core_cnt == 0);
            end else begin
                bus.DONE = 1'b0;
            end
            if (manual_done) bus.DONE = 1'b1;
            if (bus.GO && core_en) core_cnt = 3;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_btn();
        bus.SW_START = 1'b1;
        tick(10);
        bus.SW_START = 1'b0;
        tick(10);
    endtask

    task automatic set_mode(input logic [1:0] m);
        bus.SW_MODE = m;
        tick(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
    endtask

    task automatic wait_go();
        int n;
        n = go_count;
        for (int i = 0; i < 100 && go_count == n; i++) tick(1);
        check("go_seen", 32'(go_count > n), 32'd1);
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 200 && !bus.HALTED; i++) tick(1);
        check("halt_seen", 32'(bus.HALTED), 32'd1);
    endtask

    initial begin
        int n0;
        rst          = 1'b1;
        bus.SW_START = 1'b0;
        bus.SW_MODE  = 2'b00;
        bus.SW_INST  = 8'h00;
        tick(3);
        check("rst_pc",     32'(bus.PC),     32'd0);
        check("rst_inst",   32'(bus.INST),   32'h00);
        check("rst_go",     32'(bus.GO),     32'd0);
        check("rst_busy",   32'(bus.BUSY),   32'd0);
        check("rst_halted", 32'(bus.HALTED), 32'd0);
        check("rst_err",    32'(bus.ERR),    32'd0);
        rst = 1'b0;
        tick(10);

        // Bouncing press in load mode: exactly one store at PC 0.
        bus.SW_INST = 8'h31;
        for (int i = 0; i < 5; i++) begin
            bus.SW_START = ~bus.SW_START;
            tick(2);
        end
        tick(10);
        bus.SW_START = 1'b0;
        tick(10);
        check("bounce_pc",   32'(bus.PC),     32'd1);
        check("bounce_mem0", 32'(dut.mem[0]), 32'h31);

        bus.SW_INST = 8'h52;
        press_btn();
        bus.SW_INST = 8'hFF;
        press_btn();
        check("load_pc", 32'(bus.PC), 32'd3);

        // Single step from PC 0.
        do_reset();
        check("step_pc0", 32'(bus.PC), 32'd0);
        set_mode(2'b01);
        core_en = 1'b1;
        n0 = go_count;
        press_btn();
        check("step_gos",   32'(go_count),   32'(n0 + 1));
        check("step_inst",  32'(go_inst[n0]), 32'h31);
        check("step_pc",    32'(bus.PC),     32'd1);
        check("step_busy",  32'(bus.BUSY),   32'd0);
        check("step_halt",  32'(bus.HALTED), 32'd0);

        // DONE while idle must not advance PC.
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        tick(4);
        check("idle_done_pc", 32'(bus.PC), 32'd1);

        // Run until the HALT_INST at PC 2.
        do_reset();
        set_mode(2'b10);
        n0 = go_count;
        press_btn();
        wait_halt();
        check("run_gos",   32'(go_count),       32'(n0 + 3));
        check("run_inst0", 32'(go_inst[n0]),     32'h31);
        check("run_inst1", 32'(go_inst[n0 + 1]), 32'h52);
        check("run_inst2", 32'(go_inst[n0 + 2]), 32'hFF);
        check("run_pc",    32'(bus.PC),         32'd3);
        check("run_err",   32'(bus.ERR),        32'd0);
        tick(20);
        press_btn();
        check("halt_nogo",  32'(go_count),   32'(n0 + 3));
        check("halt_pc",    32'(bus.PC),     32'd3);
        check("halt_stays", 32'(bus.HALTED), 32'd1);

        set_mode(2'b00);
        check("unhalt_halted", 32'(bus.HALTED), 32'd0);
        check("unhalt_pc",     32'(bus.PC),     32'd0);

        // Timeout: DONE withheld.
        core_en = 1'b0;
        set_mode(2'b01);
        n0 = go_count;
        press_btn();
        wait_halt();
        check("tmo_err",    32'(bus.ERR),          32'd1);
        check("tmo_pc",     32'(bus.PC),           32'd0);
        check("tmo_cycles", 32'(halt_cyc - go_cyc), 32'd16);
        check("tmo_gos",    32'(go_count),         32'(n0 + 1));
        set_mode(2'b00);
        check("tmo_clr_err",  32'(bus.ERR),    32'd0);
        check("tmo_clr_halt", 32'(bus.HALTED), 32'd0);
        check("tmo_clr_pc",   32'(bus.PC),     32'd0);
        check("tmo_clr_busy", 32'(bus.BUSY),   32'd0);

        // Fill all 16 entries, then run across the PC wrap.
        for (int i = 0; i < 16; i++) begin
            bus.SW_INST = 8'h10 + 8'(i);
            press_btn();
        end
        check("wrap_load_pc", 32'(bus.PC),      32'd0);
        check("wrap_mem15",   32'(dut.mem[15]), 32'h1F);
        core_en = 1'b1;
        set_mode(2'b10);
        n0 = go_count;
        bus.SW_START = 1'b1;
        for (int i = 0; i < 400 && go_count < n0 + 18; i++) tick(1);
        bus.SW_START = 1'b0;
        check("wrap_gos",    32'(go_count >= n0 + 18), 32'd1);
        check("wrap_inst15", 32'(go_inst[n0 + 15]),     32'h1F);
        check("wrap_inst16", 32'(go_inst[n0 + 16]),     32'h10);
        check("wrap_inst17", 32'(go_inst[n0 + 17]),     32'h11);

        // Reset one cycle after GO, with the core's DONE still pending.
        wait_go();
        tick(1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_pc",     32'(bus.PC),     32'd0);
        check("mid_rst_go",     32'(bus.GO),     32'd0);
        check("mid_rst_busy",   32'(bus.BUSY),   32'd0);
        check("mid_rst_inst",   32'(bus.INST),   32'h00);
        check("mid_rst_halted", 32'(bus.HALTED), 32'd0);
        check("mid_rst_err",    32'(bus.ERR),    32'd0);
        rst = 1'b0;
        n0 = go_count;
        tick(10);
        check("late_done_pc",   32'(bus.PC),   32'd0);
        check("late_done_busy", 32'(bus.BUSY), 32'd0);
        check("late_done_gos",  32'(go_count), 32'(n0));

        check("go_single_cycle", 32'(go_double), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
